// File: rtl/rx_uart_if.sv
// rx_uart_if: serial-line and received-byte signals of the rx_uart receiver
// Ports (modport slave = receiver side):
//   rx          in   serial line, idle high
//   baud_sel    in   3-bit baud select
//   data        out  last correctly received byte
//   valid       out  one-cycle pulse when data updates
//   framing_err out  one-cycle pulse on a low stop bit
//   parity_err  out  one-cycle pulse on an even-parity mismatch
//   busy        out  high while a frame is being received
interface rx_uart_if;
    logic       rx;
    logic [2:0] baud_sel;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       parity_err;
    logic       busy;
    modport master (output rx, baud_sel, input data, valid, framing_err, parity_err, busy);
    modport slave  (input rx, baud_sel, output data, valid, framing_err, parity_err, busy);
endinterface

// File: rtl/rx_uart.sv
// rx_uart: UART receiver, 8N1 by default, 8E1 when RX_UART_PARITY_EN is defined
// Ports:
//   clk  in  system clock (50 MHz), rising edge
//   rst  in  synchronous active-high reset
//   bus  rx_uart_if.slave: rx, baud_sel in; data, valid, framing_err, parity_err, busy out
// Optional macro: RX_UART_PARITY_EN adds the even-parity bit and the PARITY state.
module rx_uart (
    input logic      clk,
    input logic      rst,
    rx_uart_if.slave bus
);
`ifdef RX_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    logic par_ok;
    logic perr;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    state_t      state;
    logic        rx_q, rx_s, rx_p;
    logic [14:0] cnt, cpb, cpb_sel;
    logic [2:0]  bit_idx;
    logic [7:0]  sh, dat;
    logic        vld, ferr, bsy;
    logic        full_hit, half_hit;
    assign cpb_sel = bus.baud_sel == 3'd1 ? 15'd5208 :
                     bus.baud_sel == 3'd2 ? 15'd10417 :
                     bus.baud_sel == 3'd3 ? 15'd20833 : 15'd434;
    // cpb is the baud divisor latched at start detection
    assign full_hit = cnt == cpb - 15'd1;
    assign half_hit = cnt == (cpb >> 1) - 15'd1;
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_q    <= 1'b1;
            rx_s    <= 1'b1;
            rx_p    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            cpb     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            dat     <= '0;
            vld     <= 1'b0;
            ferr    <= 1'b0;
            bsy     <= 1'b0;
`ifdef RX_UART_PARITY_EN
            par_ok  <= 1'b1;
            perr    <= 1'b0;
`endif
        end else begin
            rx_q <= bus.rx;
            rx_s <= rx_q;
            rx_p <= rx_s;
            vld  <= 1'b0;
            ferr <= 1'b0;
`ifdef RX_UART_PARITY_EN
            perr <= 1'b0;
`endif
            cnt  <= cnt + 15'd1;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    // rx_p must be high, so a line held low after a framing error cannot restart
                    if (rx_p && !rx_s) begin
                        state <= START;
                        bsy   <= 1'b1;
                        cpb   <= cpb_sel;
                    end
                end
                START: if (half_hit) begin
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                        bsy   <= 1'b0;
                    end else
                        state <= DATA;
                end
                DATA: if (full_hit) begin
                    cnt     <= '0;
                    sh      <= {rx_s, sh[7:1]};
                    bit_idx <= bit_idx + 3'd1;
`ifdef RX_UART_PARITY_EN
                    if (bit_idx == 3'd7) state <= PARITY;
`else
                    if (bit_idx == 3'd7) state <= STOP;
`endif
                end
`ifdef RX_UART_PARITY_EN
                PARITY: if (full_hit) begin
                    cnt    <= '0;
                    par_ok <= rx_s == ^sh;
                    state  <= STOP;
                end
`endif
                STOP: if (full_hit) begin
                    cnt   <= '0;
                    state <= IDLE;
                    bsy   <= 1'b0;
                    if (!rx_s)
                        ferr <= 1'b1;
`ifdef RX_UART_PARITY_EN
                    else if (!par_ok)
                        perr <= 1'b1;
`endif
                    else begin
                        vld <= 1'b1;
                        dat <= sh;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.data        = dat;
    assign bus.valid       = vld;
    assign bus.framing_err = ferr;
    assign bus.busy        = bsy;
`ifdef RX_UART_PARITY_EN
    assign bus.parity_err  = perr;
`else
    assign bus.parity_err  = 1'b0;
`endif
endmodule

// File: doc/rx_uart.md
RX_UART -- requirements
Module: rx_uart

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-high.
REQ-002 Port: clk  input  1  system clock, 50 MHz; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: rx  input  1  asynchronous serial line; idle high.
REQ-005 Port: baud_sel  input  3  baud select: 0 -> 115200, 1 -> 9600, 2 -> 4800, 3 -> 2400, 4-7 -> 115200.
REQ-006 Port: data  output  8  last correctly received byte.
REQ-007 Port: valid  output  1  one-cycle pulse when data is updated.
REQ-008 Port: framing_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-009 Port: parity_err  output  1  one-cycle pulse when the parity check fails (see Configuration).
REQ-010 Port: busy  output  1  high from start-bit detection until the frame ends.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-012 Cycles per bit (CPB) SHALL be 434, 5208, 10417 or 20833 for 115200, 9600, 4800 or 2400; HALF SHALL be CPB/2, truncated.
REQ-013 The bit counter SHALL be 15 bits wide and SHALL clear on every state change.
REQ-014 baud_sel SHALL be latched on start detection; changes mid-frame SHALL have no effect until the next frame.
REQ-015 States SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-016 IDLE: a falling edge on rx_s (previous 1, current 0) SHALL move to START and set busy.
REQ-017 START: at count == HALF-1, rx_s == 0 SHALL move to DATA; rx_s == 1 is a false start and SHALL return to IDLE with busy low and no pulses.
REQ-018 DATA: at each count == CPB-1, rx_s SHALL be shifted in LSB first and bit_index incremented.
REQ-019 DATA: after the 8th sample, the FSM SHALL move to STOP, or to PARITY when the macro is defined.
REQ-020 STOP: at count == CPB-1, rx_s == 1 SHALL load data from the shift register and pulse valid for exactly one cycle.
REQ-021 STOP: rx_s == 0 at that sample SHALL pulse framing_err, SHALL NOT pulse valid, and SHALL leave data unchanged.
REQ-022 After the stop sample, the FSM SHALL enter IDLE in the next cycle and busy SHALL drop.
REQ-023 After a framing error, a new frame SHALL NOT start until rx_s has been high for at least one cycle.
REQ-024 Latency: valid SHALL assert 3 + HALF + 9*CPB cycles (+/-2) after the first clk edge that sees rx low.
REQ-025 valid, framing_err and parity_err SHALL be mutually exclusive in any cycle.
REQ-026 data SHALL hold its value between valid pulses; there is no overrun flag, and a newer byte overwrites it.

Reset
REQ-027 While rst is high: state = IDLE, data = 0x00, valid = 0, framing_err = 0, parity_err = 0, busy = 0, counters = 0, synchronizer flops = 1.
REQ-028 Reset mid-frame SHALL abort the frame with no pulse; reception SHALL resume on the first falling edge after rst deasserts.

Configuration
REQ-029 Macro RX_UART_PARITY_EN defined: the frame SHALL carry one even-parity bit after the 8 data bits, handled in the PARITY state and sampled at count == CPB-1.
REQ-030 With the macro defined, a parity mismatch SHALL pulse parity_err at the stop sample instead of valid and SHALL leave data unchanged.
REQ-031 With the macro defined, a framing error SHALL take precedence over a parity error.
REQ-032 Macro undefined: there SHALL be no PARITY state, the frame SHALL be 10 bits, and parity_err SHALL be tied to 0.

Verification
REQ-033 baud_sel=0, frame 0x55 with good stop -> data=0x55, valid high exactly 1 cycle, busy low afterward.
REQ-034 baud_sel=1, frames 0xA3 then 0x0F back-to-back with no idle gap -> two valid pulses; data=0xA3, then data=0x0F.
REQ-035 baud_sel=0, 100-cycle low glitch on rx -> no valid, no framing_err; busy returns low by cycle ~220.
REQ-036 baud_sel=0, frame 0x3C with stop bit low -> framing_err 1 cycle, no valid, data keeps its previous value.
REQ-037 baud_sel=3, rst pulsed during data bit 4, then a frame 0x81 -> no pulse from the aborted frame; then data=0x81 with valid.
REQ-038 With RX_UART_PARITY_EN defined, frame 0x07 with parity bit 0 (wrong) -> parity_err 1 cycle, no valid; the same frame with parity bit 1 -> valid, data=0x07.
